eth_pcs_rx_link_ctrl: RTL and testbench
=======================================

// Module: eth_pcs_rx_link_ctrl
// PURPOSE
//  Supervises the 10GBASE-R RX alignment path: consumes gearbox sync headers and the block-sync lock flag.
//  Runs a Clause 49 style BER monitor (fixed-length windows, bad-header threshold) and drives o_hi_ber / o_rx_status.
//  Pulses o_restart to reset the RX gearbox and block sync after persistent high BER.
//  Sits between eth_pcs_rx_gearbox / block sync and the RX decoder / status registers.
// PARAMETERS
//  W_SYNC          2      sync header width
//  TIMER_CYCLES    40283  BER window length in i_clk cycles (125 us @ 322.265625 MHz)
//  BER_THRESH      16     bad headers in one window that declare hi_ber
//  HIBER_RESTART   8      consecutive hi_ber windows before a restart
//  RESTART_HOLD    4      o_restart pulse length in cycles
//  W_BER_CNT       6      width of the saturating status error counter
// PORTS
//  i_clk            in   1          clock (RX recovered clock domain)
//  i_reset          in   1          synchronous, active-high reset
//  i_hdr_valid      in   1          i_hdr qualifier (gearbox o_grbx_hdr_valid)
//  i_hdr            in   W_SYNC     sync header (gearbox o_grbx_hdr)
//  i_rx_lock        in   1          block lock from block sync
//  i_ber_cnt_clr    in   1          clear-on-read strobe for o_ber_cnt
//  o_hi_ber         out  1          high BER declared
//  o_rx_status      out  1          lock & !hi_ber & not restarting
//  o_restart        out  1          reset request to gearbox + block sync (ORed with i_reset at top)
//  o_ber_cnt        out  W_BER_CNT  saturating bad-header count
// BEHAVIOUR
//  - Bad header: i_hdr_valid & (i_hdr==2'b00 | i_hdr==2'b11).
//  - Good headers (01, 10) are ignored.
//  - All outputs are registered; an input in cycle n affects outputs after edge n+1.
//  - Reset: state=IDLE, timer=0, bad_cnt=0, win_cnt=0.
//    Reset values: o_hi_ber=0, o_rx_status=0, o_restart=0, o_ber_cnt=0.
//  - FSM states: IDLE, WINDOW, HI_BER, RESTART.
//  - IDLE:
//    o_hi_ber=0; counters held at 0.
//    i_rx_lock=1 -> WINDOW; timer and bad_cnt start from 0.
//  - WINDOW:
//    timer increments every cycle; bad_cnt increments on each bad header.
//    Bad header that makes bad_cnt==BER_THRESH -> HI_BER, o_hi_ber=1, timer keeps running.
//    Timer reaches TIMER_CYCLES-1 with bad_cnt<BER_THRESH -> new WINDOW, o_hi_ber=0, win_cnt=0.
//    Threshold hit and expiry in the same cycle: threshold wins (-> HI_BER).
//  - HI_BER:
//    o_hi_ber=1; bad headers do not advance bad_cnt.
//    On timer expiry win_cnt+1. If win_cnt+1==HIBER_RESTART -> RESTART, else -> WINDOW.
//    On the -> WINDOW path, timer and bad_cnt restart from 0 and o_hi_ber stays 1 until a clean window expires.
//  - RESTART:
//    o_restart=1 for exactly RESTART_HOLD cycles, then -> IDLE.
//    o_hi_ber stays 1 during the pulse and clears on entry to IDLE.
//    i_rx_lock is ignored during the pulse.
//  - Lock loss (i_rx_lock=0) in WINDOW/HI_BER -> IDLE on the next edge; timer, bad_cnt, win_cnt cleared.
//  - o_rx_status = i_rx_lock & !hi_ber & state!=RESTART, registered.
//  - o_ber_cnt:
//    +1 on each bad header in WINDOW/HI_BER; saturates at 2^W_BER_CNT-1; no wrap.
//    Not cleared by lock loss or restart.
//    i_ber_cnt_clr alone -> 0; clr together with a bad header -> 1.
//  - Widths: timer is $clog2(TIMER_CYCLES) bits; bad_cnt is $clog2(BER_THRESH+1) bits; win_cnt is $clog2(HIBER_RESTART+1) bits.
//  - i_hdr is don't-care when i_hdr_valid=0.
//  - i_reset mid-operation (including mid-RESTART pulse) -> reset values on the next edge; the o_restart pulse is truncated.
// TESTING (sim uses TIMER_CYCLES=64, BER_THRESH=16, HIBER_RESTART=3, RESTART_HOLD=4)
//  1. Lock=1, all headers 01/10 for 5 windows -> o_hi_ber=0, o_rx_status=1 from 2 cycles after lock, o_ber_cnt=0.
//  2. 16 bad headers (2'b11) within one window -> o_hi_ber=1 one cycle after the 16th.
//     Next window clean -> o_hi_ber=0 after its expiry.
//  3. 15 bad headers per window for 4 windows -> o_hi_ber never set.
//     o_ber_cnt=60, then after one more window of 15 bad headers saturates at 63.
//  4. 16 bad headers in each of 3 consecutive windows -> o_restart high exactly 4 cycles.
//     o_rx_status=0 during the pulse; FSM in IDLE afterwards.
//  5. Drop i_rx_lock mid-HI_BER -> next cycle o_hi_ber=0, o_rx_status=0.
//     Relock -> fresh window with bad_cnt=0.
//  6. i_ber_cnt_clr coincident with a bad header at o_ber_cnt=40 -> o_ber_cnt=1.
//     i_reset during RESTART -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/eth_pcs_rx_link_ctrl.sv
// eth_pcs_rx_link_ctrl: 10GBASE-R RX link supervisor. Runs a windowed
// bad-sync-header BER monitor and requests a gearbox/block-sync restart.
// Ports:
//   i_clk, i_reset        RX recovered clock, synchronous active-high reset
//   i_hdr_valid, i_hdr    sync header and its qualifier from the gearbox
//   i_rx_lock             block lock from block sync
//   i_ber_cnt_clr         clear-on-read strobe for o_ber_cnt
//   o_hi_ber              high BER declared
//   o_rx_status           locked, not high BER, not restarting
//   o_restart             RESTART_HOLD-cycle reset request
//   o_ber_cnt             saturating bad-header count
module eth_pcs_rx_link_ctrl #(
  parameter int W_SYNC        = 2,
  parameter int TIMER_CYCLES  = 40283,
  parameter int BER_THRESH    = 16,
  parameter int HIBER_RESTART = 8,
  parameter int RESTART_HOLD  = 4,
  parameter int W_BER_CNT     = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_hdr_valid,
  input  logic [W_SYNC-1:0]    i_hdr,
  input  logic                 i_rx_lock,
  input  logic                 i_ber_cnt_clr,
  output logic                 o_hi_ber,
  output logic                 o_rx_status,
  output logic                 o_restart,
  output logic [W_BER_CNT-1:0] o_ber_cnt
);

  localparam int TW = $clog2(TIMER_CYCLES);
  localparam int BW = $clog2(BER_THRESH + 1);
  localparam int WW = $clog2(HIBER_RESTART + 1);
  localparam int HW = $clog2(RESTART_HOLD + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_CYCLES - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(BER_THRESH - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(HIBER_RESTART - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESTART_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WINDOW,
    HI_BER,
    RESTART
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bad_q, bad_d;
  logic [WW-1:0]        win_q, win_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 hi_ber_q, hi_ber_d;
  logic                 status_q, status_d;
  logic                 restart_q, restart_d;
  logic [W_BER_CNT-1:0] cnt_q, cnt_d;

  logic bad_hdr;
  logic expire;
  logic monitoring;

  assign bad_hdr = i_hdr_valid &
                   ((i_hdr == '0) | (i_hdr == '1));
  assign expire = (timer_q == TIMER_LAST);
  assign monitoring = (state_q == WINDOW) |
                      (state_q == HI_BER);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bad_d     = bad_q;
    win_d     = win_q;
    hold_d    = '0;
    hi_ber_d  = hi_ber_q;
    restart_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d  = '0;
        bad_d    = '0;
        win_d    = '0;
        hi_ber_d = 1'b0;
        if (i_rx_lock) state_d = WINDOW;
      end
      WINDOW: begin
        if (!i_rx_lock) begin
          state_d  = IDLE;
          timer_d  = '0;
          bad_d    = '0;
          win_d    = '0;
          hi_ber_d = 1'b0;
        end else begin
          timer_d = expire ? '0 : timer_q + TW'(1);
          // threshold outranks a coincident window expiry
          if (bad_hdr && bad_q == BAD_LAST) begin
            bad_d    = bad_q + BW'(1);
            state_d  = HI_BER;
            hi_ber_d = 1'b1;
          end else if (expire) begin
            bad_d    = '0;
            win_d    = '0;
            hi_ber_d = 1'b0;
          end else if (bad_hdr) begin
            bad_d = bad_q + BW'(1);
          end
        end
      end
      HI_BER: begin
        if (!i_rx_lock) begin
          state_d  = IDLE;
          timer_d  = '0;
          bad_d    = '0;
          win_d    = '0;
          hi_ber_d = 1'b0;
        end else begin
          timer_d  = expire ? '0 : timer_q + TW'(1);
          hi_ber_d = 1'b1;
          if (expire) begin
            bad_d = '0;
            if (win_q == WIN_LAST) begin
              state_d   = RESTART;
              win_d     = '0;
              restart_d = 1'b1;
            end else begin
              state_d = WINDOW;
              win_d   = win_q + WW'(1);
            end
          end
        end
      end
      RESTART: begin
        hi_ber_d  = 1'b1;
        restart_d = 1'b1;
        hold_d    = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          hi_ber_d  = 1'b0;
          restart_d = 1'b0;
          hold_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // status needs one cycle in a monitoring state, so it
  // trails lock by two edges
  assign status_d = i_rx_lock & ~hi_ber_d & monitoring &
                    (state_d != RESTART);

  always_comb begin
    cnt_d = cnt_q;
    if (i_ber_cnt_clr) begin
      cnt_d = (bad_hdr & monitoring) ? W_BER_CNT'(1) : '0;
    end else if (bad_hdr && monitoring && cnt_q != '1) begin
      cnt_d = cnt_q + W_BER_CNT'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bad_q     <= '0;
      win_q     <= '0;
      hold_q    <= '0;
      hi_ber_q  <= 1'b0;
      status_q  <= 1'b0;
      restart_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bad_q     <= bad_d;
      win_q     <= win_d;
      hold_q    <= hold_d;
      hi_ber_q  <= hi_ber_d;
      status_q  <= status_d;
      restart_q <= restart_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_hi_ber    = hi_ber_q;
  assign o_rx_status = status_q;
  assign o_restart   = restart_q;
  assign o_ber_cnt   = cnt_q;

endmodule

// File: tb/tb_eth_pcs_rx_link_ctrl.sv
// Bench for eth_pcs_rx_link_ctrl: per-cycle vector table plus
// window-level sequences with hand-computed expectations.
module tb_eth_pcs_rx_link_ctrl;

  logic       clk;
  logic       rst;
  logic       hv;
  logic [1:0] hdr;
  logic       lock;
  logic       clr;
  logic       hi_ber;
  logic       status;
  logic       restart;
  logic [5:0] ber_cnt;

  int checks = 0;
  int errors = 0;

  logic hist_hi [64];
  logic hist_st [64];
  logic hist_rs [64];

  eth_pcs_rx_link_ctrl #(
    .W_SYNC(2),
    .TIMER_CYCLES(64),
    .BER_THRESH(16),
    .HIBER_RESTART(3),
    .RESTART_HOLD(4),
    .W_BER_CNT(6)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_hdr_valid(hv),
    .i_hdr(hdr),
    .i_rx_lock(lock),
    .i_ber_cnt_clr(clr),
    .o_hi_ber(hi_ber),
    .o_rx_status(status),
    .o_restart(restart),
    .o_ber_cnt(ber_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       hv;
    logic [1:0] hdr;
    logic       clr;
    logic       hi;
    logic       st;
    logic       rs;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] h,
                     input logic c);
    hv  = v;
    hdr = h;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    lock = 1'b0;
    cyc(1'b0, 2'b00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic lock_up();
    lock = 1'b1;
    cyc(1'b0, 2'b01, 1'b0);
  endtask

  // first nbad cycles carry bad headers (alternating 00/11)
  task automatic run_win(input int nbad, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      if (k < nbad) cyc(1'b1, (k % 2 == 1) ? 2'b11 : 2'b00, 1'b0);
      else          cyc(1'b1, (k % 2 == 1) ? 2'b10 : 2'b01, 1'b0);
      hist_hi[k] = hi_ber;
      hist_st[k] = status;
      hist_rs[k] = restart;
    end
  endtask

  logic any_hi, any_nst;
  int   nrs;
  logic pr [8];
  logic ph [8];
  logic ps [8];

  initial begin
    rst = 1'b1; lock = 1'b0; hv = 1'b0; hdr = 2'b00; clr = 1'b0;

    //         rst  lk  hv  hdr   clr  hi  st  rs  cnt
    vecs[0]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0, 6'd0};
    vecs[1]  = '{0, 1, 0, 2'b00, 0, 0, 0, 0, 6'd0};
    vecs[2]  = '{0, 1, 1, 2'b01, 0, 0, 1, 0, 6'd0};
    vecs[3]  = '{0, 1, 1, 2'b11, 0, 0, 1, 0, 6'd1};
    vecs[4]  = '{0, 1, 1, 2'b00, 0, 0, 1, 0, 6'd2};
    vecs[5]  = '{0, 1, 1, 2'b10, 0, 0, 1, 0, 6'd2};
    vecs[6]  = '{0, 1, 0, 2'b11, 0, 0, 1, 0, 6'd2};
    vecs[7]  = '{0, 1, 0, 2'b00, 1, 0, 1, 0, 6'd0};
    vecs[8]  = '{0, 1, 1, 2'b00, 0, 0, 1, 0, 6'd1};
    vecs[9]  = '{0, 1, 1, 2'b11, 1, 0, 1, 0, 6'd1};
    vecs[10] = '{0, 1, 1, 2'b11, 0, 0, 1, 0, 6'd2};
    vecs[11] = '{0, 0, 1, 2'b11, 0, 0, 0, 0, 6'd3};
    vecs[12] = '{0, 0, 1, 2'b11, 0, 0, 0, 0, 6'd3};
    vecs[13] = '{0, 0, 1, 2'b00, 1, 0, 0, 0, 6'd0};
    vecs[14] = '{1, 0, 0, 2'b00, 0, 0, 0, 0, 6'd0};
    vecs[15] = '{0, 1, 1, 2'b11, 0, 0, 0, 0, 6'd0};
    vecs[16] = '{0, 1, 0, 2'b00, 0, 0, 1, 0, 6'd0};

    for (int i = 0; i < 17; i++) begin
      rst  = vecs[i].rst;
      lock = vecs[i].lock;
      cyc(vecs[i].hv, vecs[i].hdr, vecs[i].clr);
      chk($sformatf("vec%0d_hi_ber", i), 32'(hi_ber), 32'(vecs[i].hi));
      chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].st));
      chk($sformatf("vec%0d_restart", i), 32'(restart), 32'(vecs[i].rs));
      chk($sformatf("vec%0d_ber_cnt", i), 32'(ber_cnt), 32'(vecs[i].cnt));
    end

    // 1: clean windows
    do_reset();
    lock_up();
    chk("t1_status_after_first_edge", 32'(status), 0);
    any_hi = 1'b0; any_nst = 1'b0;
    for (int w = 0; w < 5; w++) begin
      run_win(0, 64);
      for (int k = 0; k < 64; k++) begin
        any_hi  = any_hi | hist_hi[k];
        any_nst = any_nst | ~hist_st[k];
      end
    end
    chk("t1_hi_ber_seen", 32'(any_hi), 0);
    chk("t1_status_low_seen", 32'(any_nst), 0);
    chk("t1_ber_cnt", 32'(ber_cnt), 0);

    // 2: threshold then clean recovery window
    run_win(16, 64);
    chk("t2_hi_after_15", 32'(hist_hi[14]), 0);
    chk("t2_hi_after_16", 32'(hist_hi[15]), 1);
    chk("t2_status_in_hiber", 32'(hist_st[15]), 0);
    chk("t2_hi_at_expiry", 32'(hist_hi[63]), 1);
    run_win(0, 64);
    chk("t2_hi_before_clean_exp", 32'(hist_hi[62]), 1);
    chk("t2_hi_after_clean_exp", 32'(hist_hi[63]), 0);
    chk("t2_status_after_clean", 32'(hist_st[63]), 1);
    chk("t2_ber_cnt", 32'(ber_cnt), 16);

    // 3: just under threshold, counter saturation
    do_reset();
    lock_up();
    any_hi = 1'b0;
    for (int w = 0; w < 4; w++) begin
      run_win(15, 64);
      for (int k = 0; k < 64; k++) any_hi = any_hi | hist_hi[k];
    end
    chk("t3_hi_ber_seen", 32'(any_hi), 0);
    chk("t3_ber_cnt_60", 32'(ber_cnt), 60);
    run_win(15, 64);
    chk("t3_ber_cnt_sat", 32'(ber_cnt), 63);
    chk("t3_status", 32'(status), 1);

    // 4: three hi_ber windows -> restart pulse
    do_reset();
    lock_up();
    run_win(16, 64);
    run_win(16, 64);
    run_win(16, 64);
    chk("t4_restart_before", 32'(hist_rs[62]), 0);
    chk("t4_restart_start", 32'(hist_rs[63]), 1);
    chk("t4_status_start", 32'(hist_st[63]), 0);
    nrs = 1;
    lock = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 2'b11, 1'b0);
      pr[j] = restart;
      ph[j] = hi_ber;
      ps[j] = status;
      if (restart) nrs++;
    end
    chk("t4_restart_len", 32'(nrs), 4);
    chk("t4_restart_last", 32'(pr[2]), 1);
    chk("t4_restart_end", 32'(pr[3]), 0);
    chk("t4_hi_during", 32'(ph[2]), 1);
    chk("t4_hi_idle", 32'(ph[3]), 0);
    chk("t4_status_pulse", 32'(ps[1]), 0);
    chk("t4_status_idle", 32'(ps[7]), 0);
    chk("t4_ber_cnt_idle", 32'(ber_cnt), 48);

    // 5: lock loss in HI_BER and relock
    do_reset();
    lock_up();
    run_win(16, 20);
    chk("t5_hi_set", 32'(hist_hi[19]), 1);
    lock = 1'b0;
    cyc(1'b0, 2'b01, 1'b0);
    chk("t5_hi_lock_loss", 32'(hi_ber), 0);
    chk("t5_status_lock_loss", 32'(status), 0);
    lock_up();
    run_win(16, 64);
    chk("t5_fresh_hi_15", 32'(hist_hi[14]), 0);
    chk("t5_fresh_hi_16", 32'(hist_hi[15]), 1);
    chk("t5_ber_cnt_kept", 32'(ber_cnt), 32);

    // 6: clear with bad header, reset during restart
    do_reset();
    lock_up();
    run_win(40, 40);
    chk("t6_ber_cnt_40", 32'(ber_cnt), 40);
    cyc(1'b1, 2'b11, 1'b1);
    chk("t6_clr_with_bad", 32'(ber_cnt), 1);
    run_win(0, 23);
    run_win(16, 64);
    run_win(16, 64);
    chk("t6_restart_start", 32'(hist_rs[63]), 1);
    rst = 1'b1;
    cyc(1'b0, 2'b01, 1'b0);
    chk("t6_rst_restart", 32'(restart), 0);
    chk("t6_rst_hi_ber", 32'(hi_ber), 0);
    chk("t6_rst_status", 32'(status), 0);
    chk("t6_rst_ber_cnt", 32'(ber_cnt), 0);
    rst = 1'b0;
    cyc(1'b0, 2'b01, 1'b0);
    chk("t6_restart_truncated", 32'(restart), 0);
    chk("t6_status_idle", 32'(status), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
